// File: rtl/clk_mon_if.sv
// rtl/clk_mon_if.sv - control, sampled-signal and result bundle for the clock monitor
interface clk_mon_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic                    en;
  logic [NUM_CH-1:0]       sig_in;
  logic                    clr_err;
  logic [NUM_CH*CNT_W-1:0] period_meas;
  logic [NUM_CH*CNT_W-1:0] high_meas;
  logic [NUM_CH-1:0]       meas_valid;
  logic [NUM_CH-1:0]       period_err;
  logic [NUM_CH-1:0]       high_err;
  logic [NUM_CH-1:0]       low_err;
  logic [NUM_CH-1:0]       stuck_err;
  logic                    err_any;

  modport master (
    output en, sig_in, clr_err,
    input  period_meas, high_meas, meas_valid, period_err, high_err, low_err, stuck_err, err_any
  );

  modport slave (
    input  en, sig_in, clr_err,
    output period_meas, high_meas, meas_valid, period_err, high_err, low_err, stuck_err, err_any
  );
endinterface

// File: rtl/clk_mon.sv
// rtl/clk_mon.sv - multi-channel period/high/low clock monitor; optional stuck detect via CLK_MON_STUCK_EN
module clk_mon #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int EXP_HIGH   = 5,
  parameter int TOL        = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  clk_mon_if.slave mon
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [CNT_W:0]   EXP_P = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   EXP_H = (CNT_W+1)'(EXP_HIGH);
  localparam logic [CNT_W:0]   EXP_L = (CNT_W+1)'(EXP_PERIOD - EXP_HIGH);
  localparam logic [CNT_W:0]   TOL_W = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] ONE   = 1;

  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] a, input logic [CNT_W:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  logic err_any_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic             sig, sig_q, rise;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] per_inc, hi_inc;
    logic [CNT_W-1:0] per_meas_q, hi_meas_q;
    logic             meas_fire, valid_q;
    logic             per_err_q, hi_err_q, lo_err_q;
    logic             per_bad, hi_bad, lo_bad;
    logic [CNT_W:0]   p_ext, h_ext, l_ext;

    assign sig     = mon.sig_in[i];
    assign rise    = sig & ~sig_q;
    assign per_inc = (&per_cnt_q) ? per_cnt_q : per_cnt_q + ONE;
    assign hi_inc  = (&hi_cnt_q) ? hi_cnt_q : hi_cnt_q + ONE;

    // Checks look at the window that closes on this rise; high time never exceeds period.
    assign p_ext   = {1'b0, per_cnt_q};
    assign h_ext   = {1'b0, hi_cnt_q};
    assign l_ext   = p_ext - h_ext;
    assign per_bad = (&per_cnt_q) || (abs_diff(p_ext, EXP_P) > TOL_W);
    assign hi_bad  = abs_diff(h_ext, EXP_H) > TOL_W;
    assign lo_bad  = abs_diff(l_ext, EXP_L) > TOL_W;

`ifdef CLK_MON_STUCK_EN
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(TIMEOUT - 1);
    logic [AGE_W-1:0] age_q;
    logic             any_edge, timeout, stuck_set, stuck_q;

    assign any_edge = sig ^ sig_q;
    assign timeout  = (state_q == MEAS) && !any_edge && (age_q == AGE_LIM);

    // Edge-age counter: cleared by any edge or while idle/disabled, flags stuck on reaching TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        age_q   <= '0;
        stuck_q <= 1'b0;
      end else begin
        if (!mon.en || state_q == IDLE || any_edge) age_q <= '0;
        else if (age_q != AGE_LIM)                 age_q <= age_q + 1'b1;
        stuck_q <= stuck_set | (stuck_q & ~mon.clr_err);
      end
    end

    assign mon.stuck_err[i] = stuck_q;
`else
    assign mon.stuck_err[i] = 1'b0;
`endif

    // Next-state and counter update for the IDLE/MEAS channel machine.
    always_comb begin
      state_d   = state_q;
      per_cnt_d = per_cnt_q;
      hi_cnt_d  = hi_cnt_q;
      meas_fire = 1'b0;
`ifdef CLK_MON_STUCK_EN
      stuck_set = 1'b0;
`endif
      if (!mon.en) begin
        state_d   = IDLE;
        per_cnt_d = '0;
        hi_cnt_d  = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_d   = MEAS;
              per_cnt_d = ONE;
              hi_cnt_d  = ONE;
            end
          end
          MEAS: begin
`ifdef CLK_MON_STUCK_EN
            if (timeout) begin
              stuck_set = 1'b1;
              state_d   = IDLE;
              per_cnt_d = '0;
              hi_cnt_d  = '0;
            end else
`endif
            if (rise) begin
              meas_fire = 1'b1;
              per_cnt_d = ONE;
              hi_cnt_d  = ONE;
            end else begin
              per_cnt_d = per_inc;
              if (sig) hi_cnt_d = hi_inc;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // State, previous sample and window counters.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= IDLE;
        sig_q     <= 1'b0;
        per_cnt_q <= '0;
        hi_cnt_q  <= '0;
      end else begin
        state_q   <= state_d;
        sig_q     <= sig;
        per_cnt_q <= per_cnt_d;
        hi_cnt_q  <= hi_cnt_d;
      end
    end

    // Measurement capture and sticky error flags; a set beats a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        per_meas_q <= '0;
        hi_meas_q  <= '0;
        valid_q    <= 1'b0;
        per_err_q  <= 1'b0;
        hi_err_q   <= 1'b0;
        lo_err_q   <= 1'b0;
      end else begin
        valid_q <= meas_fire;
        if (meas_fire) begin
          per_meas_q <= per_cnt_q;
          hi_meas_q  <= hi_cnt_q;
        end
        per_err_q <= (meas_fire & per_bad) | (per_err_q & ~mon.clr_err);
        hi_err_q  <= (meas_fire & hi_bad)  | (hi_err_q  & ~mon.clr_err);
        lo_err_q  <= (meas_fire & lo_bad)  | (lo_err_q  & ~mon.clr_err);
      end
    end

    assign mon.period_meas[i*CNT_W +: CNT_W] = per_meas_q;
    assign mon.high_meas[i*CNT_W +: CNT_W]   = hi_meas_q;
    assign mon.meas_valid[i]                 = valid_q;
    assign mon.period_err[i]                 = per_err_q;
    assign mon.high_err[i]                   = hi_err_q;
    assign mon.low_err[i]                    = lo_err_q;
  end

  // Summary flag, one cycle behind the individual error bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_any_q <= 1'b0;
    else        err_any_q <= |{mon.period_err, mon.high_err, mon.low_err, mon.stuck_err};
  end

  assign mon.err_any = err_any_q;

endmodule

// File: tb/tb_clk_mon.sv
// tb/tb_clk_mon.sv - directed bench for clk_mon (default build and CLK_MON_STUCK_EN)
module tb_clk_mon;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH-1:0] sig_a = '0;
  logic [NUM_CH-1:0] sig_b = '0;
  int n_tests = 0;
  int n_fail  = 0;
  int vcnt0   = 0;
  int base;

  always #5 clk = ~clk;

  clk_mon_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) if_a ();
  clk_mon_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) if_b ();

  assign if_a.sig_in = sig_a;
  assign if_b.sig_in = sig_b;

  clk_mon #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .EXP_PERIOD(10), .EXP_HIGH(5), .TOL(0), .TIMEOUT(TIMEOUT))
    u_dut_a (.clk(clk), .rst_n(rst_n), .mon(if_a));

  clk_mon #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .EXP_PERIOD(10), .EXP_HIGH(5), .TOL(1), .TIMEOUT(TIMEOUT))
    u_dut_b (.clk(clk), .rst_n(rst_n), .mon(if_b));

  // ch0 valid pulses of DUT A, sampled mid-cycle
  always @(negedge clk) if (if_a.meas_valid[0]) vcnt0 <= vcnt0 + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_a(input int ch, input logic v, input int n);
    sig_a[ch] = v;
    tick(n);
  endtask

  task automatic drive_b(input int ch, input logic v, input int n);
    sig_b[ch] = v;
    tick(n);
  endtask

  initial begin
    if_a.en = 1'b0; if_a.clr_err = 1'b0;
    if_b.en = 1'b0; if_b.clr_err = 1'b0;
    tick(3);
    check("rst_period", if_a.period_meas, 64'h0);
    check("rst_high", if_a.high_meas, 64'h0);
    check("rst_valid", if_a.meas_valid, 64'h0);
    check("rst_errs", {if_a.period_err, if_a.high_err, if_a.low_err, if_a.stuck_err}, 64'h0);
    check("rst_err_any", if_a.err_any, 64'h0);

    rst_n = 1'b1;
    if_a.en = 1'b1;
    if_b.en = 1'b1;
    tick(2);

    // ch0 nominal 5/5 for five periods
    base = vcnt0;
    for (int k = 0; k < 5; k++) begin
      drive_a(0, 1'b1, 5);
      drive_a(0, 1'b0, 5);
    end
    tick(2);
    check("ch0_valid_count", 64'(vcnt0 - base), 64'd4);
    check("ch0_period", if_a.period_meas[0*CNT_W +: CNT_W], 64'd10);
    check("ch0_high", if_a.high_meas[0*CNT_W +: CNT_W], 64'd5);
    check("ch0_errs", {if_a.period_err[0], if_a.high_err[0], if_a.low_err[0]}, 64'h0);
    check("ch0_err_any", if_a.err_any, 64'h0);

    // ch1 duty 6/4
    for (int k = 0; k < 3; k++) begin
      drive_a(1, 1'b1, 6);
      drive_a(1, 1'b0, 4);
    end
    tick(2);
    check("ch1_period", if_a.period_meas[1*CNT_W +: CNT_W], 64'd10);
    check("ch1_high", if_a.high_meas[1*CNT_W +: CNT_W], 64'd6);
    check("ch1_high_err", if_a.high_err, 64'b0010);
    check("ch1_low_err", if_a.low_err, 64'b0010);
    check("ch1_period_err", if_a.period_err, 64'b0000);
    check("ch1_ch0_kept", if_a.period_meas[0*CNT_W +: CNT_W], 64'd10);
    check("ch1_err_any", if_a.err_any, 64'h1);

    // clear, with err_any lagging by one cycle
    if_a.clr_err = 1'b1;
    tick(1);
    if_a.clr_err = 1'b0;
    check("clr_high_err", if_a.high_err, 64'h0);
    check("clr_low_err", if_a.low_err, 64'h0);
    check("clr_err_any_lag", if_a.err_any, 64'h1);
    tick(1);
    check("clr_err_any", if_a.err_any, 64'h0);

    // clear coinciding with a failing rise: set wins
    sig_a[1] = 1'b1;
    if_a.clr_err = 1'b1;
    tick(1);
    if_a.clr_err = 1'b0;
    check("coinc_valid", if_a.meas_valid[1], 64'h1);
    check("coinc_period_err", if_a.period_err[1], 64'h1);
    check("coinc_high_err", if_a.high_err[1], 64'h1);
    drive_a(1, 1'b0, 2);

    // TOL=1 on DUT B ch2: period 11 passes, period 12 fails
    drive_b(2, 1'b1, 5);
    drive_b(2, 1'b0, 6);
    drive_b(2, 1'b1, 1);
    check("tol_p11", if_b.period_meas[2*CNT_W +: CNT_W], 64'd11);
    check("tol_p11_err", if_b.period_err[2], 64'h0);
    drive_b(2, 1'b1, 5);
    drive_b(2, 1'b0, 6);
    drive_b(2, 1'b1, 1);
    check("tol_p12", if_b.period_meas[2*CNT_W +: CNT_W], 64'd12);
    check("tol_p12_high", if_b.high_meas[2*CNT_W +: CNT_W], 64'd6);
    check("tol_p12_err", if_b.period_err, 64'b0100);
    check("tol_p12_hl_err", {if_b.high_err, if_b.low_err}, 64'h0);
    drive_b(2, 1'b0, 2);
    if_b.clr_err = 1'b1;
    tick(1);
    if_b.clr_err = 1'b0;
    check("tol_clr", if_b.period_err, 64'h0);

    // ch3: two good periods then held high
    drive_a(3, 1'b1, 5);
    drive_a(3, 1'b0, 5);
    drive_a(3, 1'b1, 5);
    drive_a(3, 1'b0, 5);
    drive_a(3, 1'b1, 1);
    check("ch3_period", if_a.period_meas[3*CNT_W +: CNT_W], 64'd10);
    check("ch3_period_err", if_a.period_err[3], 64'h0);
`ifdef CLK_MON_STUCK_EN
    tick(TIMEOUT - 1);
    check("stuck_early", if_a.stuck_err[3], 64'h0);
    tick(1);
    check("stuck_set", if_a.stuck_err[3], 64'h1);
`else
    tick(TIMEOUT + 6);
    check("stuck_off", if_a.stuck_err, 64'h0);
`endif
    drive_a(3, 1'b0, 2);

    // async reset mid-period, then partial first window
    drive_a(0, 1'b1, 5);
    drive_a(0, 1'b0, 5);
    drive_a(0, 1'b1, 2);
    rst_n = 1'b0;
    #2;
    check("mid_rst_period", if_a.period_meas, 64'h0);
    check("mid_rst_high", if_a.high_meas, 64'h0);
    check("mid_rst_flags", {if_a.meas_valid, if_a.period_err, if_a.high_err, if_a.low_err, if_a.stuck_err, if_a.err_any}, 64'h0);
    sig_a = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    base = vcnt0;
    drive_a(0, 1'b1, 5);
    drive_a(0, 1'b0, 5);
    check("post_rst_no_valid", 64'(vcnt0 - base), 64'd0);
    drive_a(0, 1'b1, 1);
    check("post_rst_valid", if_a.meas_valid[0], 64'h1);
    check("post_rst_period", if_a.period_meas[0*CNT_W +: CNT_W], 64'd10);
    check("post_rst_high", if_a.high_meas[0*CNT_W +: CNT_W], 64'd5);
    drive_a(0, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_mon.md
# clk_mon

Multi-channel clock-quality monitor. Each channel samples a clock-like signal that is synchronous to `clk`. On every rising edge of that signal, the channel measures period, high time and low time in `clk` cycles. It then checks each measurement against parametrised expectations with a tolerance and raises sticky error flags. Used on-chip next to divided or gated clock generators; it is the synthesizable, parametrised counterpart of the period/duty checks run in simulation.

## Interface
- `NUM_CH`, 4: number of monitored channels.
- `CNT_W`, 16: width of the per-channel measurement counters.
- `EXP_PERIOD`, 10: expected period in `clk` cycles.
- `EXP_HIGH`, 5: expected high time in cycles. Expected low time = `EXP_PERIOD - EXP_HIGH`.
- `TOL`, 0: allowed absolute deviation in cycles, applied to all three checks.
- `TIMEOUT`, 64: stuck-detect limit in cycles. Used only with `CLK_MON_STUCK_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global monitor enable.
- `sig_in`  in  NUM_CH  monitored signals, synchronous to `clk`.
- `clr_err`  in  1  one-cycle pulse; clears all sticky errors.
- `period_meas`  out  NUM_CH*CNT_W  last measured period; channel i occupies bits [i*CNT_W +: CNT_W].
- `high_meas`  out  NUM_CH*CNT_W  last measured high time, same packing as `period_meas`.
- `meas_valid`  out  NUM_CH  one-cycle pulse when that channel's measurements update.
- `period_err`, `high_err`, `low_err`  out  NUM_CH each  sticky check failures.
- `stuck_err`  out  NUM_CH  sticky stuck-signal flag.
- `err_any`  out  1  OR of all error bits, registered.

## Operation
- Per channel, `sig_q` holds the previous sample of `sig_in`. A rise is `sig_in & ~sig_q`; any edge is `sig_in ^ sig_q`.
- Each channel has two states: `IDLE` and `MEAS`.
  - `IDLE`: counters held at 0. The first rise loads `per_cnt`=1 and `hi_cnt`=1 and moves to `MEAS`. This first rise produces no measurement, because the preceding window is partial.
  - `MEAS`, no rise: `per_cnt` increments every cycle; `hi_cnt` increments when `sig_in`=1.
  - `MEAS`, on rise: register `period_meas`=`per_cnt` and `high_meas`=`hi_cnt`, pulse `meas_valid`, run the checks, then reload both counters to 1.
- Counters saturate at 2^CNT_W−1 and never wrap. A saturated period always sets `period_err`.
- Checks use unsigned absolute difference computed in CNT_W+1 bits. With P = measured period and H = measured high time:
  - `period_err` sets if |P − EXP_PERIOD| > TOL.
  - `high_err` sets if |H − EXP_HIGH| > TOL.
  - `low_err` sets if |(P − H) − (EXP_PERIOD − EXP_HIGH)| > TOL.
- Error flags are sticky until `clr_err`. If `clr_err` and a new error-set occur in the same cycle, the set wins.
- `en`=0: all channels go to `IDLE` and counters clear. Measurement outputs and errors hold their values. No `meas_valid` pulses.
- Reset values: every output is 0, `sig_q`=0, all channels in `IDLE`.

## Timing
- `meas_valid`, `period_meas`, `high_meas` and the error bits are all registered. They become visible in the cycle after the `clk` edge at which `sig_in`=1 is first sampled with `sig_q`=0.
- `err_any` lags the individual error bits by one cycle.
- `clr_err` takes effect at the next edge; the error bits read 0 in the following cycle unless a set coincides.
- Asserting `rst_n` low mid-measurement clears everything immediately. After release, the first rise is again treated as partial.
- Minimum measurable period: 2 cycles. Throughput: one measurement per channel per period; channels are fully independent.

## Configuration
- `CLK_MON_STUCK_EN` defined:
  - Each channel keeps an edge-age counter, reset on any edge and on entry to `IDLE`.
  - In `MEAS`, when the counter reaches `TIMEOUT`, `stuck_err` sets (sticky, cleared by `clr_err`) and the channel returns to `IDLE`.
- `CLK_MON_STUCK_EN` not defined: `stuck_err` is tied to 0 and no age counter is built. A stuck signal instead saturates `per_cnt` and is reported through `period_err` on its next rise.

## Test plan
- Defaults; ch0 toggles 5 high / 5 low for 5 periods → 4 `meas_valid` pulses, `period_meas`=10, `high_meas`=5, no error bits set, `err_any`=0.
- Ch1 runs 6 high / 4 low → `period_meas`=10, `high_meas`=6; `high_err[1]`=1 and `low_err[1]`=1; `period_err[1]`=0; other channels unaffected.
- `TOL`=1; ch2 period 11 then 12 → period 11 sets no error; period 12 sets `period_err[2]`; pulsing `clr_err` afterwards clears it.
- `clr_err` pulsed in the same cycle a failing rise is evaluated → error bit reads 1 after that edge.
- With `CLK_MON_STUCK_EN`, ch3 held high after 2 good periods → `stuck_err[3]`=1 exactly `TIMEOUT` cycles after the last edge. Without the macro, `stuck_err` stays 0.
- `rst_n` pulsed low mid-period → all outputs read 0. The first rise after release gives no `meas_valid`; the second rise gives a correct measurement.
